seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: cycles through NUM_DIGITS digit slots and
// swaps in newly loaded content only at frame boundaries so no frame is mixed.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    tick, wrap;

  logic [3:0]            nib;
  logic                  dp_sel, en_sel, blank, acc;
  logic [NUM_DIGITS-1:0] zero_from, an_sel;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign tick = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= wrap ? '0 : idx + IW'(1);
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      // A load coinciding with the wrap bypasses pending so the next frame is fresh.
      if (wrap) begin
        disp_val <= load ? value : pend_val;
        disp_dp  <= load ? dp_in : pend_dp;
      end
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    en_sel    = 1'b0;
    an_sel    = '1;
    zero_from = '0;
    acc       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (disp_val[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = disp_val[4*i +: 4];
        dp_sel    = disp_dp[i];
        en_sel    = digit_en[i];
        an_sel[i] = 1'b0;
      end
    end
    // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0".
    blank = !en_sel || ((BLANK_LZ != 0) && (idx != '0) && (|(zero_from & ~an_sel)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode      <= '1;
      cathode    <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (blank) begin
        anode   <= '1;
        cathode <= 7'h7F;
        dp      <= 1'b1;
      end else begin
        anode   <= an_sel;
        cathode <= seg7(nib);
        dp      <= ~dp_sel;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: a plain-BLANK and a leading-zero-blanking instance
// driven together and checked every cycle against a cycle-count reference model.
module tb_seven_seg_scan;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic rst_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dp_in, digit_en;
  logic load;
  logic [6:0] cathode, cathode_lz;
  logic dp, dp_lz, frame_done, frame_done_lz;
  logic [ND-1:0] anode, anode_lz;

  int total = 0;
  int bad = 0;

  // Model state: k = edges since reset release; slot and digit derive from it.
  int k = 0;
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [3:0]  m_pdp = '0, m_ddp = '0;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .cathode(cathode), .dp(dp), .anode(anode), .frame_done(frame_done));

  seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .cathode(cathode_lz), .dp(dp_lz), .anode(anode_lz),
    .frame_done(frame_done_lz));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  // One clock: predict outputs from pre-edge state, advance model, then compare.
  task automatic step();
    logic [3:0] e_an, e_an_lz;
    logic [6:0] e_ca, e_ca_lz;
    logic e_dp, e_dp_lz, e_fd;
    int id;
    logic lzb;
    if (!rst_n) begin
      e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      e_an_lz = 4'hF; e_ca_lz = 7'h7F; e_dp_lz = 1'b1;
      k = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
    end else begin
      id = (k / RD) % ND;
      if (!digit_en[id]) begin
        e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = ~(4'b0001 << id);
        e_ca = seg_tab[(m_disp >> (4*id)) & 16'hF];
        e_dp = ~m_ddp[id];
      end
      lzb = (id > 0) && ((m_disp >> (4*id)) == 16'd0);
      if (lzb) begin
        e_an_lz = 4'hF; e_ca_lz = 7'h7F; e_dp_lz = 1'b1;
      end else begin
        e_an_lz = e_an; e_ca_lz = e_ca; e_dp_lz = e_dp;
      end
      e_fd = ((k % FRAME) == FRAME - 1);
      if (load) begin m_pend = value; m_pdp = dp_in; end
      if ((k % FRAME) == FRAME - 1) begin m_disp = m_pend; m_ddp = m_pdp; end
      k++;
    end
    @(posedge clk);
    #1;
    chk("anode", {4'h0, anode}, {4'h0, e_an});
    chk("cathode", {1'b0, cathode}, {1'b0, e_ca});
    chk("dp", {7'h0, dp}, {7'h0, e_dp});
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    chk("anode_lz", {4'h0, anode_lz}, {4'h0, e_an_lz});
    chk("cathode_lz", {1'b0, cathode_lz}, {1'b0, e_ca_lz});
    chk("dp_lz", {7'h0, dp_lz}, {7'h0, e_dp_lz});
    chk("frame_done_lz", {7'h0, frame_done_lz}, {7'h0, e_fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst_n = 1'b0; value = '0; dp_in = '0; digit_en = 4'hF; load = 1'b0;
    run(3);
    rst_n = 1'b1;
    // First edge after release: digit 0 showing "0", checked against constants too.
    step();
    chk("first_anode", {4'h0, anode}, 8'h0E);
    chk("first_cathode", {1'b0, cathode}, 8'h01);
    run(31);

    // Mid-frame load, then a few frames showing 3,C,5,A.
    run(5);
    pulse_load(16'hA5C3, 4'h0);
    run(40);

    // Load exactly in the wrapping-tick cycle.
    while ((k % FRAME) != FRAME - 1) step();
    pulse_load(16'h1234, 4'h0);
    run(20);

    // Leading-zero blanking patterns.
    pulse_load(16'h0050, 4'h0);
    run(36);
    pulse_load(16'h0000, 4'h0);
    run(36);

    // Per-digit enable and decimal points.
    digit_en = 4'b1011;
    pulse_load(16'h8421, 4'b0001);
    run(36);
    digit_en = 4'hF;

    // Reset for one cycle mid-slot on digit 2 after a pending load.
    pulse_load(16'h9876, 4'hF);
    while (!(((k / RD) % ND) == 2 && (k % RD) == 1)) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_anode", {4'h0, anode}, 8'h0E);
    chk("post_rst_cathode", {1'b0, cathode}, 8'h01);
    run(40);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      value = 16'($urandom);
      dp_in = 4'($urandom);
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      load = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1'b1; load = 1'b0;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
